// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/handshake bundle between the ID/MEM stages and the stall scheduler.
// Valid/ready note: no ready path exists here; dmem_req is qualified by dmem_ack in the same cycle.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic             load_dep;
    logic [1:0]       pcsource;
    logic             mdu_op;
    logic             dmem_req;
    logic             dmem_ack;

    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             ex_hold;
    logic             mem_hold;
    logic             mdu_busy;
    logic [CNT_W-1:0] stall_count;

    // Pipeline side: raises hazards, consumes enables.
    modport master (
        output id_valid, load_dep, pcsource, mdu_op, dmem_req, dmem_ack,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, mem_hold, mdu_busy,
        input  stall_count
    );

    // Scheduler side.
    modport slave (
        input  id_valid, load_dep, pcsource, mdu_op, dmem_req, dmem_ack,
        output pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, mem_hold, mdu_busy,
        output stall_count
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline: turns ID hazards and the MEM
// handshake into PC / IF/ID / ID/EX controls, and counts cycles where the PC is frozen.
module pipe_stall_ctrl #(
    parameter int MDU_LAT    = 4,
    parameter int LD_BUBBLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    pipe_stall_ctrl_if.slave     bus,
    output logic [1:0]           dbg_state,
    output logic [3:0]           dbg_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_MDU_BUSY = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_t;

    localparam logic [3:0] MDU_INIT = 4'(MDU_LAT - 1);
    // The detect cycle in RUN is already the first bubble, so LD_STALL covers the rest.
    localparam logic [3:0] LD_INIT  = (LD_BUBBLES > 1) ? 4'(LD_BUBBLES - 2) : 4'd0;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic mem_stall;
    logic redirect;
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic ex_hold;
    logic mem_hold;
    logic mdu_busy;

    always_comb begin
        mem_stall   = bus.dmem_req & ~bus.dmem_ack;
        redirect    = (bus.pcsource != 2'b00);

        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        ex_hold     = 1'b0;
        mem_hold    = 1'b0;
        mdu_busy    = 1'b0;

        if (clr) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = ST_RUN;
            cnt_d       = 4'd0;
        end else begin
            unique case (state_q)
                // MEM_WAIT only differs from RUN while the access is still outstanding.
                ST_RUN, ST_MEM_WAIT: begin
                    if (mem_stall) begin
                        pc_we    = 1'b0;
                        ifid_we  = 1'b0;
                        mem_hold = 1'b1;
                        state_d  = ST_MEM_WAIT;
                    end else begin
                        state_d = ST_RUN;
                        if (bus.id_valid && bus.mdu_op) begin
                            cnt_d   = MDU_INIT;
                            state_d = ST_MDU_BUSY;
                        end else if (bus.id_valid && bus.load_dep) begin
                            pc_we       = 1'b0;
                            ifid_we     = 1'b0;
                            idex_bubble = 1'b1;
                            cnt_d       = LD_INIT;
                            state_d     = (LD_BUBBLES > 1) ? ST_LD_STALL : ST_RUN;
                        end else if (bus.id_valid && redirect) begin
                            ifid_flush = 1'b1;
                        end
                    end
                end
                ST_MDU_BUSY: begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    mdu_busy = 1'b1;
                    if (mem_stall) begin
                        mem_hold = 1'b1;
                    end else begin
                        ex_hold = 1'b1;
                        if (cnt_q == 4'd0) state_d = ST_RUN;
                        else               cnt_d   = cnt_q - 4'd1;
                    end
                end
                ST_LD_STALL: begin
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    if (mem_stall) begin
                        mem_hold = 1'b1;
                    end else begin
                        idex_bubble = 1'b1;
                        if (cnt_q == 4'd0) state_d = ST_RUN;
                        else               cnt_d   = cnt_q - 4'd1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        if (clr)                          stall_count_d = '0;
        else if (!pc_we && !(&stall_count_q)) stall_count_d = stall_count_q + CNT_ONE;
        else                              stall_count_d = stall_count_q;
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        cnt_q         <= cnt_d;
        stall_count_q <= stall_count_d;
    end

    assign bus.pc_we       = pc_we;
    assign bus.ifid_we     = ifid_we;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.ex_hold     = ex_hold;
    assign bus.mem_hold    = mem_hold;
    assign bus.mdu_busy    = mdu_busy;
    assign bus.stall_count = stall_count_q;
    assign dbg_state       = state_q;
    assign dbg_cnt         = cnt_q;

endmodule
